// File: rtl/el_tdc_res_if.sv
// Result channel of the TDC: measured count plus timeout flag,
// qualified by a valid/ready handshake.
interface el_tdc_res_if #(
  parameter int unsigned CNT_W = 8
);
  logic [CNT_W-1:0] res_data;
  logic             res_timeout;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output res_data,
    output res_timeout,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_timeout,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/el_tdc.sv
// Race-logic time-to-digital converter: counts clock cycles from start until a
// synchronised rising edge on ev_in, saturating at all ones with a timeout flag.
module el_tdc #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ev_in,
  output logic          en_out,
  output logic          busy,
  el_tdc_res_if.master  res
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ev_sync;
  logic                   ev_prev_q;
  logic                   ev_rise;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       res_data_q;
  logic                   res_timeout_q;

  // Synchroniser and edge detector run in every state, so a level already
  // present when RUN is entered never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      ev_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ev_in};
      ev_prev_q <= ev_sync;
    end
  end

  assign ev_sync = sync_q[SYNC_STAGES-1];
  assign ev_rise = ev_sync & ~ev_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (ev_rise || (cnt_q == CntMax)) state_d = StDone;
      StDone: if (res.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Count and result registers; an edge wins over saturation in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (start) cnt_q <= '0;
        StRun: begin
          if (ev_rise) begin
            res_data_q    <= cnt_q;
            res_timeout_q <= 1'b0;
          end else if (cnt_q == CntMax) begin
            res_data_q    <= CntMax;
            res_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    en_out        = 1'b0;
    busy          = 1'b0;
    res.res_valid = 1'b0;
    unique case (state_q)
      StRun: begin
        en_out = 1'b1;
        busy   = 1'b1;
      end
      StDone: begin
        busy          = 1'b1;
        res.res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign res.res_data    = res_data_q;
  assign res.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_el_tdc.sv
// Self-checking bench for el_tdc: expected results are queued when a
// measurement is launched and compared when the DUT presents res_valid.
module tb_el_tdc;

  localparam int CntW   = 8;
  localparam int Sync   = 2;
  localparam int Max    = (1 << CntW) - 1;
  localparam int Budget = 400;

  typedef struct packed {
    logic [31:0] data;
    logic        tmo;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ev_in;
  logic en_out;
  logic busy;

  el_tdc_res_if #(.CNT_W(CntW)) res_if ();

  el_tdc #(
    .CNT_W      (CntW),
    .SYNC_STAGES(Sync)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ev_in (ev_in),
    .en_out(en_out),
    .busy  (busy),
    .res   (res_if)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  res_t last_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: an edge driven in the RUN cycle with count c is seen
  // Sync cycles later; if that lands past the maximum count, it times out.
  task automatic push_event(input int c);
    res_t e;
    if (c < 0 || c + Sync > Max) begin
      e.data = Max;
      e.tmo  = 1'b1;
    end else begin
      e.data = c + Sync;
      e.tmo  = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  // Returns at the falling edge inside the RUN cycle with count 0.
  task automatic start_meas();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic get_result(input string tag, output int waited);
    waited = 0;
    while (!res_if.res_valid && waited < Budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " valid"}, 32'(res_if.res_valid), 1);
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check({tag, " data"}, 32'(res_if.res_data), last_exp.data);
      check({tag, " timeout"}, 32'(res_if.res_timeout), 32'(last_exp.tmo));
    end
    check({tag, " en_out done"}, 32'(en_out), 0);
  endtask

  task automatic ack(input string tag);
    res_if.res_ready = 1'b1;
    @(negedge clk);
    res_if.res_ready = 1'b0;
    check({tag, " valid after ack"}, 32'(res_if.res_valid), 0);
    check({tag, " busy after ack"}, 32'(busy), 0);
    ev_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int w;
    rst              = 1'b0;
    start            = 1'b0;
    ev_in            = 1'b0;
    res_if.res_ready = 1'b0;
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset en_out", 32'(en_out), 0);
    check("reset valid", 32'(res_if.res_valid), 0);
    check("reset data", 32'(res_if.res_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // res_ready while idle must not disturb anything
    res_if.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    res_if.res_ready = 1'b0;
    check("idle ready busy", 32'(busy), 0);
    check("idle ready valid", 32'(res_if.res_valid), 0);

    // Edge in the cnt=10 cycle reports 12
    start_meas();
    check("run en_out", 32'(en_out), 1);
    check("run busy", 32'(busy), 1);
    push_event(10);
    repeat (10) @(negedge clk);
    ev_in = 1'b1;
    get_result("basic", w);
    ack("basic");

    // No event: timeout after exactly 256 RUN cycles
    start_meas();
    push_event(-1);
    get_result("timeout", w);
    check("timeout latency", 32'(w), Max + 1);
    ack("timeout");

    // Level already high never counts
    ev_in = 1'b1;
    repeat (4) @(negedge clk);
    start_meas();
    push_event(-1);
    get_result("level high", w);
    res_if.res_ready = 1'b1;
    @(negedge clk);
    res_if.res_ready = 1'b0;
    start_meas();
    push_event(20);
    repeat (5) @(negedge clk);
    ev_in = 1'b0;
    repeat (15) @(negedge clk);
    ev_in = 1'b1;
    get_result("fresh edge", w);
    ack("fresh edge");

    // Result held under backpressure, start ignored in DONE
    start_meas();
    push_event(7);
    repeat (7) @(negedge clk);
    ev_in = 1'b1;
    get_result("hold", w);
    ev_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      @(negedge clk);
      check("hold data", 32'(res_if.res_data), last_exp.data);
      check("hold valid", 32'(res_if.res_valid), 1);
    end
    start = 1'b0;
    ack("hold");
    check("no queued start", 32'(busy), 0);

    // Edge detected exactly at the saturation count wins over timeout
    start_meas();
    push_event(Max - Sync);
    repeat (Max - Sync) @(negedge clk);
    ev_in = 1'b1;
    get_result("edge at max", w);
    ack("edge at max");

    // Reset mid-RUN discards the measurement
    start_meas();
    repeat (50) @(negedge clk);
    check("pre-reset busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 0);
    check("async rst en_out", 32'(en_out), 0);
    check("async rst valid", 32'(res_if.res_valid), 0);
    check("async rst data", 32'(res_if.res_data), 0);
    check("async rst timeout", 32'(res_if.res_timeout), 0);
    @(negedge clk);
    check("in rst valid", 32'(res_if.res_valid), 0);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first start honoured", 32'(busy), 1);
    push_event(3);
    repeat (3) @(negedge clk);
    ev_in = 1'b1;
    get_result("after reset", w);
    ack("after reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
